// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA serial datapath blocks.
//   collector_state_t : FSM encoding of the serial-to-parallel collector
//   cnt_width()       : bit counter width needed to count 0..width
package rsa_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } collector_state_t;

    localparam int unsigned COLLECTOR_DEFAULT_WIDTH = 8;
    localparam int unsigned COLLECTOR_DEFAULT_CNT_W = $clog2(COLLECTOR_DEFAULT_WIDTH + 1);

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_shift_collector.sv
// bit_shift_collector: LSB-first serial-to-parallel receiver.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   ce       : global clock enable, all state frozen when low
//   en       : bit-valid qualifier while collecting
//   start    : begin a new word; b_i in this cycle is bit 0
//   b_i      : serial data, LSB first
//   word_o   : last completed word, held until next completion
//   valid_o  : one-cycle pulse in the cycle after the last bit is captured
//   busy_o   : high while a word is being collected
module bit_shift_collector
    import rsa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  en,
    input  logic                  start,
    input  logic                  b_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    collector_state_t      r_state;
    collector_state_t      w_state_nxt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] w_sr_nxt;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] w_word_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;

    // New bit enters at the MSB so the first bit ends up in bit 0.
    if (DATA_WIDTH == 1) begin : g_shift_w1
        assign w_shift = b_i;
    end else begin : g_shift_wn
        assign w_shift = {b_i, r_sr[DATA_WIDTH-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_valid_nxt = 1'b0;

        if (start) begin
            // Start (or abort-and-restart): b_i is bit 0 of a fresh word.
            w_sr_nxt = w_shift;
            if (DATA_WIDTH == 1) begin
                w_word_nxt  = w_shift;
                w_valid_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = SHIFT;
            end
        end else if (r_state == SHIFT && en) begin
            w_sr_nxt = w_shift;
            if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                w_word_nxt  = w_shift;
                w_valid_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (ce) begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign word_o  = r_word;
    assign valid_o = r_valid;
    assign busy_o  = (r_state == SHIFT);

endmodule

// File: tb/tb_bit_shift_collector.sv
// Self-checking bench for bit_shift_collector: an 8-bit and a 1-bit instance share the
// same stimulus; a behavioural model predicts words into scoreboard queues and per-cycle
// output values, and a monitor compares on the falling edge.
module tb_bit_shift_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       en;
    logic       start;
    logic       b_i;
    logic [7:0] word8;
    logic       valid8;
    logic       busy8;
    logic [0:0] word1;
    logic       valid1;
    logic       busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_shift_collector #(.DATA_WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .en      (en),
        .start   (start),
        .b_i     (b_i),
        .word_o  (word8),
        .valid_o (valid8),
        .busy_o  (busy8)
    );

    bit_shift_collector #(.DATA_WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .en      (en),
        .start   (start),
        .b_i     (b_i),
        .word_o  (word1),
        .valid_o (valid1),
        .busy_o  (busy1)
    );

    // ---------------- reference model ----------------
    logic [7:0] q8[$];
    logic       q1[$];
    bit         m_coll;
    int         m_nbits;
    logic [7:0] m_acc;
    logic [7:0] exp_word8;
    bit         exp_valid8;
    bit         exp_busy8;
    logic       exp_word1;
    bit         exp_valid1;
    bit         last_ce;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_coll = 0; m_nbits = 0; m_acc = '0;
            exp_word8 = '0; exp_valid8 = 0; exp_busy8 = 0;
            exp_word1 = 1'b0; exp_valid1 = 0;
            last_ce = 0;
            q8.delete();
            q1.delete();
        end else begin
            last_ce = ce;
            if (ce) begin
                exp_valid8 = 0;
                exp_valid1 = 0;
                if (start) begin
                    // A start always begins a new word; anything in flight is dropped.
                    m_acc = '0;
                    m_acc[0] = b_i;
                    m_nbits = 1;
                    m_coll = 1;
                    exp_word1 = b_i;
                    exp_valid1 = 1;
                    q1.push_back(b_i);
                end else if (m_coll && en) begin
                    m_acc[m_nbits] = b_i;
                    m_nbits++;
                    if (m_nbits == 8) begin
                        exp_word8 = m_acc;
                        exp_valid8 = 1;
                        q8.push_back(m_acc);
                        m_coll = 0;
                    end
                end
                exp_busy8 = m_coll;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        chk("busy8", {7'd0, busy8}, {7'd0, exp_busy8});
        chk("valid8", {7'd0, valid8}, {7'd0, exp_valid8});
        chk("word8_held", word8, exp_word8);
        chk("busy1", {7'd0, busy1}, 8'd0);
        chk("valid1", {7'd0, valid1}, {7'd0, exp_valid1});
        if (valid8 === 1'b1 && last_ce) begin
            if (q8.size() == 0) chk("sb8_unexpected", word8, 8'hxx);
            else chk("sb8_word", word8, q8.pop_front());
        end
        if (valid1 === 1'b1 && last_ce) begin
            if (q1.size() == 0) chk("sb1_unexpected", {7'd0, word1}, 8'hxx);
            else chk("sb1_word", {7'd0, word1}, {7'd0, q1.pop_front()});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic b, input logic e, input logic c);
        start = s; b_i = b; en = e; ce = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 0; i < 8; i++) cyc(i == 0, w[i], 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 1'($urandom), 1'b1);
    endtask

    logic [7:0] w;

    initial begin
        rst = 1'b1; ce = 1'b0; en = 1'b0; start = 1'b0; b_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_word8", word8, 8'h00);
        chk("reset_busy8", {7'd0, busy8}, 8'h00);
        idle(2);

        // Basic word 0x85.
        send_byte(8'h85);
        chk("basic_valid", {7'd0, valid8}, 8'h01);
        chk("basic_word", word8, 8'h85);
        idle(3);

        // Gapped 0x85: en gap after bit 3, ce gap after bit 5.
        w = 8'h85;
        for (int i = 0; i < 8; i++) begin
            cyc(i == 0, w[i], 1'b1, 1'b1);
            if (i == 3) for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 5) for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0); // valid held across ce=0
        chk("gap_valid_hold", {7'd0, valid8}, 8'h01);
        idle(3);

        // Abort after 4 bits of 0xFF, restart with 0x3C.
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(i == 0, 1'b1, 1'b1, 1'b1);
        chk("abort_word_held", word8, 8'h00);
        send_byte(8'h3C);
        chk("abort_word", word8, 8'h3C);
        idle(2);

        // Back-to-back 0xA5 then 0x5A, second start in the valid cycle.
        send_byte(8'hA5);
        send_byte(8'h5A);
        chk("b2b_word", word8, 8'h5A);
        idle(2);

        // Reset mid-word after bit 5 of 0xC3.
        w = 8'hC3;
        for (int i = 0; i < 6; i++) cyc(i == 0, w[i], 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_busy", {7'd0, busy8}, 8'h00);
        chk("rst_valid", {7'd0, valid8}, 8'h00);
        chk("rst_word", word8, 8'h00);
        chk("rst_word1", {7'd0, word1}, 8'h00);
        #2;
        rst = 1'b0;
        send_byte(8'h81);
        chk("after_rst_word", word8, 8'h81);
        idle(2);

        // Randomized traffic: gaps, ce stalls, aborts, back-to-back starts.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 11) == 0), 1'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) != 0));
        end
        idle(12);

        chk("sb8_drained", 8'(q8.size()), 8'd0);
        chk("sb1_drained", 8'(q1.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_shift_collector.md
# bit_shift_collector

Serial-to-parallel receiver for the LSB-first bit streams produced by the serial bit-shift arithmetic blocks in the RSA datapath. It samples one bit per enabled cycle after a `start` pulse and assembles `DATA_WIDTH` bits into a parallel word. When the word is complete it raises a one-cycle `valid_o`. It closes the serial path between a bit-serial adder or multiplier output and the word-wide registers of the modular-exponentiation controller.

## Interface
- `DATA_WIDTH`, default 8: word width in bits. Must be ≥ 1.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `ce` input, 1 bit: global clock enable. When low, all state is frozen.
- `en` input, 1 bit: bit-valid qualifier. `b_i` is sampled only when `en=1` (except on a `start` cycle).
- `start` input, 1 bit: begins a new word. `b_i` in this cycle is bit 0.
- `b_i` input, 1 bit: serial data, LSB first.
- `word_o` output, `DATA_WIDTH` bits: last completed word. Held until the next completion.
- `valid_o` output, 1 bit: one-cycle pulse in the cycle after the last bit is captured.
- `busy_o` output, 1 bit: high while a word is being collected (state SHIFT).

## Operation
- Every register updates only on a rising `clk` edge with `ce=1`. With `ce=0`, the state, counter, shift register, `word_o` and `valid_o` all hold their values.
- Reset values: state IDLE, `sr`=0, `cnt`=0, `word_o`=0, `valid_o`=0, `busy_o`=0.
- Shift register `sr[DATA_WIDTH-1:0]`:
  - On each capture: `sr <= {b_i, sr[DATA_WIDTH-1:1]}`.
  - After `DATA_WIDTH` captures, bit 0 holds the first bit received.
- Counter `cnt`:
  - Width is `$clog2(DATA_WIDTH+1)`.
  - It counts captured bits.
  - It never exceeds `DATA_WIDTH-1` when stored.
- FSM states: IDLE and SHIFT.
  - IDLE, `start=1`: capture `b_i`, set `cnt=1`.
    - If `DATA_WIDTH==1`, complete immediately and stay in IDLE.
    - Otherwise go to SHIFT.
  - IDLE, `start=0`: `en` and `b_i` are ignored.
  - SHIFT, `start=0`, `en=1`: capture `b_i` and increment `cnt`.
    - If this is capture number `DATA_WIDTH`: `word_o <=` the shifted value, `valid_o <= 1`, `cnt <= 0`, go to IDLE.
  - SHIFT, `en=0`: hold. Gaps of any length are allowed.
  - SHIFT, `start=1`: abort the current word and restart. `b_i` becomes the new bit 0 and `cnt=1`. No `valid_o` is produced for the aborted word, and `word_o` is unchanged.
- A completion cycle that also has `start=1` (back-to-back words):
  - The completion happens only when the last capture occurs in SHIFT.
  - A `start` in the same cycle takes priority as an abort, per the rule above. The transmitter must assert `start` no earlier than the cycle after the last bit.
  - `start` in the cycle where `valid_o` is high is legal. It starts the next word with no bubble.
- `valid_o` is cleared on every `ce=1` edge where no completion occurs.
- `busy_o` is the registered state decode: `busy_o = (state==SHIFT)`.
- `rst` asserted mid-word: the word is discarded immediately (asynchronously) and every output returns to its reset value.

## Timing
- `start` is sampled at edge E0. The remaining bits are sampled at the next `DATA_WIDTH-1` edges with `en=1`.
- With `en` continuously high: `word_o` and `valid_o` update at edge E(`DATA_WIDTH-1`). `valid_o` is therefore high during the cycle after the last bit, which is a latency of 1 cycle from the last bit.
- With `DATA_WIDTH=1`: `valid_o` is high in the cycle right after `start`.
- `ce=0` stretches all timing. A `valid_o` that is high remains high until the next `ce=1` edge.
- There are no combinational paths from inputs to outputs.

## Structure
- A shared package `rsa_pkg` holds:
  - the `typedef enum logic {IDLE, SHIFT} collector_state_t`;
  - the helper `localparam` for the counter width.
- The block is a single module with no sub-modules. The shift register, counter and FSM fit in about 150 lines.
- Within the codebase, `bit_shift_collector` is the receive-side counterpart of the serial bit-shift adder. The integration bench connects the adder's serial output to `b_i`.

## Test plan
- Basic word (`DATA_WIDTH=8`, `ce=en=1`): `start` with bits 1,0,1,0,0,0,0,1 LSB-first → `word_o=8'h85`, `valid_o` high for exactly one cycle, 8 cycles after the `start` edge. `busy_o` is high for cycles 1–7.
- Gapped stream: the same 0x85 with `en=0` for 3 cycles after bit 3 and `ce=0` for 2 cycles after bit 5 → `word_o=8'h85`. `valid_o` is delayed by 5 cycles and is one `ce`-cycle wide.
- Abort/restart: send 4 bits of 0xFF, then `start` with 0x3C → a single `valid_o` with `word_o=8'h3C`. `word_o` stays 0 until that point.
- Back-to-back words: 0xA5 followed by `start` in the `valid_o` cycle with 0x5A → two `valid_o` pulses 8 cycles apart, `word_o` 0xA5 then 0x5A.
- Reset mid-word: assert `rst` after bit 5 of 0xC3 → `busy_o`, `valid_o` and `word_o` all 0 immediately. A following full 0x81 yields `word_o=8'h81`.
- `DATA_WIDTH=1`: `start` with `b_i=1` → `word_o=1'b1` and `valid_o` the next cycle. `busy_o` never asserts.
